// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : EX/MEM pipeline register and MEM stage of the pipelined
//                LEGv8 core. Runs a req/ack data-memory handshake for
//                loads/stores, stalls the upstream pipe while memory is
//                busy, resolves CBZ/B and drives the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int N        = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         ex_valid,
    input  logic         ex_regWrite,
    input  logic         ex_memRead,
    input  logic         ex_memWrite,
    input  logic         ex_memtoReg,
    input  logic         ex_branch,
    input  logic         ex_zero,
    input  logic [N-1:0] ex_aluResult,
    input  logic [N-1:0] ex_writeData,
    input  logic [N-1:0] ex_PCBranch,
    input  logic [4:0]   ex_rd,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         stall_o,
    output logic         mem_err_o,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic [4:0]   EX_MEM_rd,
    output logic         EX_MEM_regWrite,
    output logic [N-1:0] EX_MEM_aluResult,
    output logic         wb_valid,
    output logic         wb_regWrite,
    output logic         wb_memtoReg,
    output logic [4:0]   wb_rd,
    output logic [N-1:0] wb_aluResult,
    output logic [N-1:0] wb_readData
);

    // Counter is wide enough to hold MAX_WAIT-1 even when MAX_WAIT is 1.
    localparam int            c_cnt_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // EX/MEM register
    logic         m_valid_q,     m_valid_d;
    logic         m_regwrite_q,  m_regwrite_d;
    logic         m_memread_q,   m_memread_d;
    logic         m_memwrite_q,  m_memwrite_d;
    logic         m_memtoreg_q,  m_memtoreg_d;
    logic         m_branch_q,    m_branch_d;
    logic         m_zero_q,      m_zero_d;
    logic [N-1:0] m_alu_q,       m_alu_d;
    logic [N-1:0] m_wdata_q,     m_wdata_d;
    logic [N-1:0] m_pcbranch_q,  m_pcbranch_d;
    logic [4:0]   m_rd_q,        m_rd_d;

    // Memory transaction control
    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic                 err_q,   err_d;
    logic [N-1:0]         rdata_q, rdata_d;

    // MEM/WB register
    logic         wb_valid_q,    wb_valid_d;
    logic         wb_regwrite_q, wb_regwrite_d;
    logic         wb_memtoreg_q, wb_memtoreg_d;
    logic [4:0]   wb_rd_q,       wb_rd_d;
    logic [N-1:0] wb_alu_q,      wb_alu_d;
    logic [N-1:0] wb_rdata_q,    wb_rdata_d;

    logic w_mem_op;
    logic w_stall;
    logic w_take;

    assign w_mem_op = m_valid_q & (m_memread_q | m_memwrite_q);
    // The completion cycle releases the stall so the next entry can load.
    assign w_stall  = w_mem_op & (state_q != ST_DONE);
    assign w_take   = ex_valid & ~flush_i;

    // EX/MEM next value: hold while stalled, otherwise load entry or bubble
    always_comb begin
        m_valid_d    = m_valid_q;
        m_regwrite_d = m_regwrite_q;
        m_memread_d  = m_memread_q;
        m_memwrite_d = m_memwrite_q;
        m_memtoreg_d = m_memtoreg_q;
        m_branch_d   = m_branch_q;
        m_zero_d     = m_zero_q;
        m_alu_d      = m_alu_q;
        m_wdata_d    = m_wdata_q;
        m_pcbranch_d = m_pcbranch_q;
        m_rd_d       = m_rd_q;
        if (!w_stall) begin
            m_valid_d    = w_take;
            m_regwrite_d = ex_regWrite & w_take;
            m_memread_d  = ex_memRead  & w_take;
            m_memwrite_d = ex_memWrite & w_take;
            m_memtoreg_d = ex_memtoReg & w_take;
            m_branch_d   = ex_branch   & w_take;
            m_zero_d     = ex_zero     & w_take;
            m_alu_d      = ex_aluResult;
            m_wdata_d    = ex_writeData;
            m_pcbranch_d = ex_PCBranch;
            m_rd_d       = ex_rd;
        end
    end

    // Memory FSM: next state, wait counter, sticky error and read capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (dm_ack) begin
                    state_d = ST_DONE;
                    rdata_d = dm_rdata;
                end else if (cnt_q == c_last_cnt) begin
                    // Timeout: finish the op with zero data and flag it.
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // MEM/WB next value: bubble while stalled, otherwise forward EX/MEM
    always_comb begin
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_memtoreg_d = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_alu_d      = wb_alu_q;
        wb_rdata_d    = wb_rdata_q;
        if (!w_stall) begin
            wb_valid_d    = m_valid_q;
            wb_regwrite_d = m_valid_q & m_regwrite_q;
            wb_memtoreg_d = m_valid_q & m_memtoreg_q;
            wb_rd_d       = m_rd_q;
            wb_alu_d      = m_alu_q;
            wb_rdata_d    = rdata_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q     <= 1'b0;
            m_regwrite_q  <= 1'b0;
            m_memread_q   <= 1'b0;
            m_memwrite_q  <= 1'b0;
            m_memtoreg_q  <= 1'b0;
            m_branch_q    <= 1'b0;
            m_zero_q      <= 1'b0;
            m_alu_q       <= '0;
            m_wdata_q     <= '0;
            m_pcbranch_q  <= '0;
            m_rd_q        <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_alu_q      <= '0;
            wb_rdata_q    <= '0;
        end else begin
            m_valid_q     <= m_valid_d;
            m_regwrite_q  <= m_regwrite_d;
            m_memread_q   <= m_memread_d;
            m_memwrite_q  <= m_memwrite_d;
            m_memtoreg_q  <= m_memtoreg_d;
            m_branch_q    <= m_branch_d;
            m_zero_q      <= m_zero_d;
            m_alu_q       <= m_alu_d;
            m_wdata_q     <= m_wdata_d;
            m_pcbranch_q  <= m_pcbranch_d;
            m_rd_q        <= m_rd_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            wb_alu_q      <= wb_alu_d;
            wb_rdata_q    <= wb_rdata_d;
        end
    end

    assign dm_req           = (state_q == ST_ACCESS);
    assign dm_we            = m_memwrite_q;
    assign dm_addr          = m_alu_q;
    assign dm_wdata         = m_wdata_q;
    assign stall_o          = w_stall;
    assign mem_err_o        = err_q;
    assign PCSrc_M          = m_valid_q & m_branch_q & m_zero_q;
    assign PCBranch_M       = m_pcbranch_q;
    assign EX_MEM_rd        = m_rd_q;
    assign EX_MEM_regWrite  = m_valid_q & m_regwrite_q;
    assign EX_MEM_aluResult = m_alu_q;
    assign wb_valid         = wb_valid_q;
    assign wb_regWrite      = wb_regwrite_q;
    assign wb_memtoReg      = wb_memtoreg_q;
    assign wb_rd            = wb_rd_q;
    assign wb_aluResult     = wb_alu_q;
    assign wb_readData      = wb_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Self-checking bench for mem_access_stage: vector table,
//                directed memory sequences and randomized traffic against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset, flush_i, ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
    logic        ex_memtoReg, ex_branch, ex_zero;
    logic [63:0] ex_aluResult, ex_writeData, ex_PCBranch;
    logic [4:0]  ex_rd;
    logic        dm_req, dm_we, dm_ack;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall_o, mem_err_o, PCSrc_M;
    logic [63:0] PCBranch_M, EX_MEM_aluResult, wb_aluResult, wb_readData;
    logic [4:0]  EX_MEM_rd, wb_rd;
    logic        EX_MEM_regWrite, wb_valid, wb_regWrite, wb_memtoReg;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_stage #(.N(64), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .ex_valid(ex_valid),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memtoReg(ex_memtoReg), .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_aluResult(ex_aluResult), .ex_writeData(ex_writeData), .ex_PCBranch(ex_PCBranch),
        .ex_rd(ex_rd), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_o(stall_o),
        .mem_err_o(mem_err_o), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regWrite(EX_MEM_regWrite),
        .EX_MEM_aluResult(EX_MEM_aluResult), .wb_valid(wb_valid),
        .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg), .wb_rd(wb_rd),
        .wb_aluResult(wb_aluResult), .wb_readData(wb_readData)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    // The entry in the MEM slot, how many cycles it has sat there, and
    // whether its memory transfer has already finished.
    bit          mv, mrw, mrd, mwr, mtr, mbr, mz;
    logic [63:0] malu, mwd, mpcb;
    logic [4:0]  mrdst;
    int          age;
    bit          done;
    bit          err;
    logic [63:0] rdat;
    bit          wv, wrw, wtr;
    logic [4:0]  wrd;
    logic [63:0] walu, wrdata;

    task automatic model_step();
        bit mop, stl, req;
        mop = mv && (mrd || mwr);
        stl = mop && !done;
        req = mop && (age >= 1) && !done;
        if (reset) begin
            {mv, mrw, mrd, mwr, mtr, mbr, mz} = '0;
            malu = '0; mwd = '0; mpcb = '0; mrdst = '0;
            age = 0; done = 0; err = 0; rdat = '0;
            {wv, wrw, wtr} = '0; wrd = '0; walu = '0; wrdata = '0;
            return;
        end
        if (stl) begin
            {wv, wrw, wtr} = '0;
        end else begin
            wv = mv; wrw = mv && mrw; wtr = mv && mtr;
            wrd = mrdst; walu = malu; wrdata = rdat;
        end
        if (req) begin
            if (dm_ack) begin
                done = 1; rdat = dm_rdata;
            end else if (age == MW) begin
                done = 1; err = 1; rdat = '0;
            end
        end
        if (!stl) begin
            mv = ex_valid && !flush_i;
            mrw = ex_regWrite && mv; mrd = ex_memRead && mv; mwr = ex_memWrite && mv;
            mtr = ex_memtoReg && mv; mbr = ex_branch && mv; mz = ex_zero && mv;
            malu = ex_aluResult; mwd = ex_writeData; mpcb = ex_PCBranch; mrdst = ex_rd;
            age = 0; done = 0;
        end else begin
            age++;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit mop;
        mop = mv && (mrd || mwr);
        chk("m.stall",  stall_o,  mop && !done);
        chk("m.dm_req", dm_req,   mop && age >= 1 && !done);
        chk("m.dm_we",  dm_we,    mwr);
        chk("m.dm_addr", dm_addr, malu);
        chk("m.dm_wdata", dm_wdata, mwd);
        chk("m.mem_err", mem_err_o, err);
        chk("m.pcsrc",  PCSrc_M,  mv && mbr && mz);
        chk("m.pcbr",   PCBranch_M, mpcb);
        chk("m.fwd_rd", EX_MEM_rd, mrdst);
        chk("m.fwd_rw", EX_MEM_regWrite, mv && mrw);
        chk("m.fwd_alu", EX_MEM_aluResult, malu);
        chk("m.wb_valid", wb_valid, wv);
        chk("m.wb_rw",  wb_regWrite, wrw);
        chk("m.wb_mtr", wb_memtoReg, wtr);
        if (wv) begin
            chk("m.wb_rd",  wb_rd, wrd);
            chk("m.wb_alu", wb_aluResult, walu);
            chk("m.wb_rdata", wb_readData, wrdata);
        end
    endtask

    // One clock: advance model with the inputs the DUT samples, then compare.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic set_ex(input bit v, rw, mr, mw, mt, br, z,
                          input logic [63:0] alu, wd, pcb, input logic [4:0] rd);
        ex_valid = v; ex_regWrite = rw; ex_memRead = mr; ex_memWrite = mw;
        ex_memtoReg = mt; ex_branch = br; ex_zero = z;
        ex_aluResult = alu; ex_writeData = wd; ex_PCBranch = pcb; ex_rd = rd;
    endtask

    task automatic set_bubble();
        set_ex(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 5'd0);
    endtask

    // Drive the handshake for the op sitting in the MEM slot; ack_at=0 never acks.
    task automatic run_mem(input int ack_at, input logic [63:0] rval,
                           output int n_st, output int n_rq, output logic we_s,
                           output logic [63:0] addr_s, output logic [63:0] wd_s);
        n_st = 0; n_rq = 0; we_s = 0; addr_s = '0; wd_s = '0;
        for (int k = 0; k < 40; k++) begin
            if (!stall_o) break;
            n_st++;
            if (dm_req) begin
                n_rq++; we_s = dm_we; addr_s = dm_addr; wd_s = dm_wdata;
            end
            dm_ack   = dm_req && (n_rq == ack_at);
            dm_rdata = dm_ack ? rval : 64'h0BAD_0BAD;
            cyc();
            dm_ack = 0;
        end
    endtask

    typedef struct {
        bit          v, fl, rw, br, z;
        logic [63:0] alu, pcb;
        logic [4:0]  rd;
        bit          e_rw, e_pcsrc;
        logic [63:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t        tbl[6];
    int          n_st, n_rq;
    logic        we_s;
    logic [63:0] addr_s, wd_s;
    bit          ack_en;

    initial begin
        //            v  fl rw br z  alu          pcb      rd    e_rw pcsrc e_alu       e_rd
        tbl[0] = '{1, 0, 1, 0, 0, 64'h2A,      64'h0,   5'd1,  1,   0,    64'h2A,     5'd1};
        tbl[1] = '{1, 0, 1, 0, 0, 64'hFFFF_0001, 64'h0, 5'd31, 1,   0,    64'hFFFF_0001, 5'd31};
        tbl[2] = '{0, 0, 1, 0, 0, 64'h77,      64'h0,   5'd4,  0,   0,    64'h77,     5'd4};
        tbl[3] = '{1, 1, 1, 1, 1, 64'h33,      64'h200, 5'd6,  0,   0,    64'h33,     5'd6};
        tbl[4] = '{1, 0, 0, 1, 0, 64'h0,       64'h300, 5'd0,  0,   0,    64'h0,      5'd0};
        tbl[5] = '{1, 0, 0, 1, 1, 64'h0,       64'h400, 5'd0,  0,   1,    64'h0,      5'd0};

        reset = 1; flush_i = 0; dm_ack = 0; dm_rdata = '0;
        set_bubble();
        cyc(); cyc();
        chk("rst.stall", stall_o, 0);
        chk("rst.dm_req", dm_req, 0);
        chk("rst.err", mem_err_o, 0);
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.fwd_alu", EX_MEM_aluResult, 0);
        reset = 0;

        // Single-cycle non-memory entries
        for (int i = 0; i < 6; i++) begin
            set_ex(tbl[i].v, tbl[i].rw, 0, 0, 0, tbl[i].br, tbl[i].z,
                   tbl[i].alu, 64'h0, tbl[i].pcb, tbl[i].rd);
            flush_i = tbl[i].fl;
            cyc();
            chk("vec.fwd_rw",  EX_MEM_regWrite, tbl[i].e_rw);
            chk("vec.fwd_alu", EX_MEM_aluResult, tbl[i].e_alu);
            chk("vec.fwd_rd",  EX_MEM_rd, tbl[i].e_rd);
            chk("vec.pcsrc",   PCSrc_M, tbl[i].e_pcsrc);
            chk("vec.stall",   stall_o, 0);
            if (i > 0) begin
                chk("vec.wb_rw", wb_regWrite, tbl[i-1].e_rw);
                chk("vec.wb_rd", wb_rd, tbl[i-1].e_rd);
            end
        end
        flush_i = 0;
        set_bubble();
        cyc();

        // LDUR 0x40, ack on third request cycle
        set_ex(1, 1, 1, 0, 1, 0, 0, 64'h40, 64'h0, 64'h0, 5'd2);
        cyc();
        set_bubble();
        run_mem(3, 64'hDEAD, n_st, n_rq, we_s, addr_s, wd_s);
        chk("ld.stall_cycles", 64'(n_st), 4);
        chk("ld.req_cycles", 64'(n_rq), 3);
        chk("ld.addr", addr_s, 64'h40);
        chk("ld.we", we_s, 0);
        cyc();
        chk("ld.wb_rdata", wb_readData, 64'hDEAD);
        chk("ld.wb_mtr", wb_memtoReg, 1);
        chk("ld.wb_rd", wb_rd, 2);

        // STUR 0x8 <- 0x55, ack on first request cycle
        set_ex(1, 0, 0, 1, 0, 0, 0, 64'h8, 64'h55, 64'h0, 5'd9);
        cyc();
        set_bubble();
        run_mem(1, 64'h1234, n_st, n_rq, we_s, addr_s, wd_s);
        chk("st.stall_cycles", 64'(n_st), 2);
        chk("st.we", we_s, 1);
        chk("st.wdata", wd_s, 64'h55);
        chk("st.addr", addr_s, 64'h8);
        cyc();
        chk("st.wb_valid", wb_valid, 1);
        chk("st.wb_rw", wb_regWrite, 0);

        // Load with no ack: timeout
        set_ex(1, 1, 1, 0, 1, 0, 0, 64'h80, 64'h0, 64'h0, 5'd3);
        cyc();
        set_bubble();
        run_mem(0, 64'h0, n_st, n_rq, we_s, addr_s, wd_s);
        chk("to.req_cycles", 64'(n_rq), MW);
        chk("to.stall_cycles", 64'(n_st), MW + 1);
        chk("to.err", mem_err_o, 1);
        cyc();
        chk("to.wb_rdata", wb_readData, 0);
        chk("to.wb_valid", wb_valid, 1);
        set_ex(1, 1, 0, 0, 0, 0, 0, 64'h9, 64'h0, 64'h0, 5'd7);
        cyc();
        set_bubble();
        cyc();
        chk("to.err_sticky", mem_err_o, 1);
        chk("to.resume_stall", stall_o, 0);
        chk("to.resume_wb", wb_rd, 7);

        // CBZ taken, next entry flushed
        set_ex(1, 0, 0, 0, 0, 1, 1, 64'h0, 64'h0, 64'h100, 5'd0);
        cyc();
        chk("cbz.pcsrc", PCSrc_M, 1);
        chk("cbz.pcbr", PCBranch_M, 64'h100);
        set_ex(1, 1, 0, 0, 0, 0, 0, 64'h5, 64'h0, 64'h0, 5'd5);
        flush_i = 1;
        cyc();
        flush_i = 0;
        chk("cbz.flushed_rw", EX_MEM_regWrite, 0);
        chk("cbz.flushed_pcsrc", PCSrc_M, 0);
        set_bubble();
        cyc();
        chk("cbz.flushed_wb", wb_valid, 0);

        // Reset in the middle of an access, then a stray ack
        set_ex(1, 1, 1, 0, 1, 0, 0, 64'h40, 64'h0, 64'h0, 5'd2);
        cyc();
        set_bubble();
        cyc();
        chk("rma.req", dm_req, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("rma.req_low", dm_req, 0);
        chk("rma.err_clr", mem_err_o, 0);
        dm_ack = 1; dm_rdata = 64'hBEEF;
        cyc();
        dm_ack = 0;
        chk("rma.wb_valid", wb_valid, 0);
        chk("rma.wb_rdata", wb_readData, 0);
        chk("rma.stall", stall_o, 0);
        chk("rma.fwd_alu", EX_MEM_aluResult, 0);

        // Randomized traffic against the model
        ack_en = 1;
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) ack_en = ($urandom_range(0, 2) != 0);
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            flush_i  = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            dm_ack   = ack_en && ($urandom_range(0, 2) == 0);
            dm_rdata = {$urandom, $urandom};
            cyc();
        end
        reset = 0; dm_ack = 0; flush_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
